iob_eth_tx_loader: RTL

Frame loader directly upstream of the MII transmitter. Accepts one Ethernet frame (destination MAC through payload, no FCS) as a byte stream, writes preamble, SFD, frame bytes and zero padding into the transmit buffer, then hands the buffer to the transmitter with a `send`/`ready` handshake. It holds the buffer untouched until the transmitter reports completion. It runs in the transmit clock domain, on the buffer write port.

---
 rtl/iob_eth_tx_loader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_tx_loader.sv
// Transmit frame loader: writes preamble, SFD, frame bytes and zero padding
// into the MII transmit buffer, then hands the buffer to the transmitter
// with a send/ready handshake. Oversize frames are drained and dropped.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for the first valid byte of a frame
// PRE       | writing preamble bytes and the SFD
// PAYLOAD   | accepting frame bytes and writing them after the SFD
// DRAIN     | oversize frame: consuming remaining bytes without writing
// PAD       | writing zero bytes until the frame reaches the minimum length
// SEND      | buffer complete, waiting for the transmitter to be idle
// WAIT_ACK  | send issued, waiting for the transmitter to go busy
// WAIT_DONE | transmitter busy, buffer must stay untouched

module iob_eth_tx_loader #(
    parameter int BUF_AW       = 11,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_LEN      = 60,
    parameter int MAX_LEN      = 1514
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [7:0]        s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic              crc_en_i,
    output logic [BUF_AW-1:0] buf_addr_o,
    output logic [7:0]        buf_data_o,
    output logic              buf_we_o,
    output logic              send_o,
    input  logic              ready_i,
    output logic [BUF_AW-1:0] nbytes_o,
    output logic              crc_en_o,
    output logic              busy_o,
    output logic              drop_o
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PAYLOAD,
        DRAIN,
        PAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam logic [BUF_AW-1:0] ONE      = BUF_AW'(1);
    localparam logic [BUF_AW-1:0] SFD_ADDR = BUF_AW'(PREAMBLE_LEN);
    localparam logic [BUF_AW-1:0] PAY_BASE = BUF_AW'(PREAMBLE_LEN + 1);
    localparam logic [BUF_AW-1:0] MIN_L    = BUF_AW'(MIN_LEN);
    localparam logic [BUF_AW-1:0] MAX_L    = BUF_AW'(MAX_LEN);

    state_t             state_q, state_d;
    logic [BUF_AW-1:0]  len_q, len_d;
    logic               crc_lat_q, crc_lat_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [BUF_AW-1:0]  addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               send_q, send_d;
    logic               drop_q, drop_d;
    logic [BUF_AW-1:0]  nbytes_q, nbytes_d;
    logic               crc_out_q, crc_out_d;
    logic               accept;

    // A beat is consumed only while the registered ready is high.
    assign accept = s_valid_i & ready_q;

    // Next-state, buffer write and handshake decode.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        crc_lat_d = crc_lat_q;
        we_d      = 1'b0;
        addr_d    = '0;
        data_d    = 8'h00;
        send_d    = 1'b0;
        drop_d    = 1'b0;
        nbytes_d  = nbytes_q;
        crc_out_d = crc_out_q;

        case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    crc_lat_d = crc_en_i;
                    len_d     = '0;
                    state_d   = PRE;
                end
            end
            PRE: begin
                // len doubles as the preamble address counter here
                we_d   = 1'b1;
                addr_d = len_q;
                if (len_q == SFD_ADDR) begin
                    data_d  = 8'hD5;
                    len_d   = '0;
                    state_d = PAYLOAD;
                end else begin
                    data_d = 8'h55;
                    len_d  = len_q + ONE;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (len_q == MAX_L) begin
                        // overflow beat is never written, so len cannot wrap
                        if (s_last_i) begin
                            drop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        we_d   = 1'b1;
                        addr_d = PAY_BASE + len_q;
                        data_d = s_data_i;
                        len_d  = len_q + ONE;
                        if (s_last_i) begin
                            if (len_d < MIN_L) begin
                                state_d = PAD;
                            end else begin
                                state_d   = SEND;
                                nbytes_d  = PAY_BASE + len_d;
                                crc_out_d = crc_lat_q;
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (accept && s_last_i) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            PAD: begin
                we_d   = 1'b1;
                addr_d = PAY_BASE + len_q;
                data_d = 8'h00;
                len_d  = len_q + ONE;
                if (len_d == MIN_L) begin
                    state_d   = SEND;
                    nbytes_d  = PAY_BASE + len_d;
                    crc_out_d = crc_lat_q;
                end
            end
            SEND: begin
                // the last write is already on the port, so send trails it
                if (ready_i) begin
                    send_d  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!ready_i) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == PAYLOAD) || (state_d == DRAIN);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            crc_lat_q <= 1'b0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= 8'h00;
            send_q    <= 1'b0;
            drop_q    <= 1'b0;
            nbytes_q  <= '0;
            crc_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            crc_lat_q <= crc_lat_d;
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            send_q    <= send_d;
            drop_q    <= drop_d;
            nbytes_q  <= nbytes_d;
            crc_out_q <= crc_out_d;
        end
    end

    assign s_ready_o  = ready_q;
    assign buf_we_o   = we_q;
    assign buf_addr_o = addr_q;
    assign buf_data_o = data_q;
    assign send_o     = send_q;
    assign drop_o     = drop_q;
    assign nbytes_o   = nbytes_q;
    assign crc_en_o   = crc_out_q;
    assign busy_o     = (state_q != IDLE);

endmodule
